// File: rtl/piano_pkg.sv
// piano_pkg: shared widths, note codes and sequencer states for the piano blocks
package piano_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] NOTE_REST = '0;
  localparam logic [DATA_W-1:0] NOTE_END = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_e;
endpackage

// File: rtl/song_player_if.sv
// song_player_if: combinational song ROM read port
interface song_player_if;
  logic [piano_pkg::ADDR_W-1:0] rom_address;
  logic [piano_pkg::DATA_W-1:0] rom_data;
  modport master(output rom_address, input rom_data);
  modport slave(input rom_address, output rom_data);
endinterface

// File: rtl/beat_timer.sv
// beat_timer: loadable down-counter that parks at zero and flags it
module beat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/song_player.sv
// song_player: steps through the song ROM, holding each note for a beat with a silent tail
module song_player
  import piano_pkg::*;
#(
  parameter int BEAT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  song_player_if.master     rom,
  output logic [DATA_W-1:0] note,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);
  localparam int TW = $clog2(BEAT_TICKS) < 1 ? 1 : $clog2(BEAT_TICKS);
  localparam logic [TW-1:0] PLAY_LD = TW'(BEAT_TICKS - GAP_TICKS - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_TICKS - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] note_q, note_d;
  logic nv_q, nv_d, busy_q, busy_d, done_q, done_d;
  logic ld, zero;
  logic [TW-1:0] ld_val;
  beat_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(ld), .load_val(ld_val), .zero(zero)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    note_d = note_q;
    nv_d = nv_q;
    ld = 1'b0;
    ld_val = PLAY_LD;
    if (stop) begin
      state_d = S_IDLE;
      addr_d = '0;
      note_d = '0;
      nv_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = start ? S_FETCH : S_IDLE;
        S_FETCH: begin
          if (rom.rom_data == NOTE_END) begin
            addr_d = '0;
            state_d = loop_en ? S_FETCH : S_DONE;
          end else begin
            note_d = rom.rom_data;
            nv_d = rom.rom_data != NOTE_REST;
            ld = 1'b1;
            state_d = S_PLAY;
          end
        end
        S_PLAY: if (zero) begin
          state_d = S_GAP;
          nv_d = 1'b0;
          ld = 1'b1;
          ld_val = GAP_LD;
        end
        S_GAP: if (zero) begin
          addr_d = addr_q != ADDR_MAX ? addr_q + ADDR_W'(1) : '0;
          state_d = (addr_q != ADDR_MAX || loop_en) ? S_FETCH : S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // a finished song leaves the tone stage silent and the ROM pointer home
    if (state_d == S_DONE) note_d = '0;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      note_q <= '0;
      nv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      note_q <= note_d;
      nv_q <= nv_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign rom.rom_address = addr_q;
  assign note = note_q;
  assign note_valid = nv_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: randomized scoreboard bench for song_player against a step-level song model
module tb_song_player;
  localparam int P = 3;
  localparam int G = 1;
  typedef struct packed {logic [4:0] a; logic [3:0] n; logic v, b, d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [3:0] note;
  logic note_valid, busy, done;
  logic [3:0] rom [32];
  exp_t sb[$];
  exp_t tr[$];
  int errors = 0, checks = 0;
  song_player_if rif();
  assign rif.rom_data = rom[rif.rom_address];
  song_player #(.BEAT_TICKS(4), .GAP_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom(rif), .note(note), .note_valid(note_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input int a, input logic [3:0] n, input logic v, b, d);
    mk.a = 5'(a); mk.n = n; mk.v = v; mk.b = b; mk.d = d;
  endfunction
  function automatic exp_t act();
    act = {rif.rom_address, note, note_valid, busy, done};
  endfunction
  task automatic chk(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got addr=%0d note=%h nv=%b busy=%b done=%b, want addr=%0d note=%h nv=%b busy=%b done=%b",
               nm, $time, a.a, a.n, a.v, a.b, a.d, e.a, e.n, e.v, e.b, e.d);
    end
  endtask
  always @(negedge clk) if (sb.size() != 0) chk("trace", act(), sb.pop_front());
  // entry 0 is the cycle in which start is presented; entry c is c cycles after it is sampled
  task automatic gen(input bit lp, input int lim);
    int a = 0;
    logic [3:0] prev = 0, d;
    bit fin = 0;
    tr.delete();
    tr.push_back(mk(0, 0, 0, 0, 0));
    while (!fin && tr.size() <= lim) begin
      d = rom[a];
      tr.push_back(mk(a, prev, 0, 1, 0));
      if (d == 4'hF) begin
        if (lp) a = 0;
        else begin tr.push_back(mk(0, 0, 0, 1, 1)); fin = 1; end
      end else begin
        repeat (P) tr.push_back(mk(a, d, d != 0, 1, 0));
        repeat (G) tr.push_back(mk(a, d, 0, 1, 0));
        prev = d;
        if (a < 31) a++;
        else if (lp) a = 0;
        else begin tr.push_back(mk(0, 0, 0, 1, 1)); fin = 1; end
      end
    end
    while (tr.size() > lim + 1) void'(tr.pop_back());
    repeat (3) tr.push_back(mk(0, 0, 0, 0, 0));
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expected cycles left, want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic txn(input bit lp, input int stopk, input bit bs);
    int bj = 0, m = 0, mx;
    @(posedge clk); #1;
    loop_en = lp;
    gen(lp, stopk == 0 ? 100000 : stopk);
    foreach (tr[i]) if (tr[i].b) m++;
    if (bs && m > 0) bj = $urandom_range(1, m);
    foreach (tr[i]) sb.push_back(tr[i]);
    start = 1'b1;
    mx = stopk > bj ? stopk : bj;
    for (int c = 1; c <= mx + 1; c++) begin
      @(posedge clk); #1;
      start = (c == bj);
      stop = (c == stopk);
    end
    drain();
  endtask
  task automatic basic_rom();
    foreach (rom[i]) rom[i] = 4'h0;
    rom[0] = 4'h1; rom[1] = 4'h5; rom[2] = 4'hF;
  endtask
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    basic_rom();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", act(), mk(0, 0, 0, 0, 0));
    start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_release", act(), mk(0, 0, 0, 0, 0));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("play_before_rst", act(), mk(0, 1, 1, 1, 0));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", act(), mk(0, 0, 0, 0, 0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rst_after", act(), mk(0, 0, 0, 0, 0));
    txn(0, 0, 0);
    rom[1] = 4'h0;
    txn(0, 0, 0);
    basic_rom();
    txn(0, 3, 0);
    txn(0, 0, 1);
    @(posedge clk); #1;
    repeat (4) sb.push_back(mk(0, 0, 0, 0, 0));
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    drain();
    foreach (rom[i]) rom[i] = 4'h3;
    txn(0, 0, 0);
    txn(1, 175, 0);
    foreach (rom[i]) rom[i] = 4'hF;
    txn(1, 9, 0);
    for (int k = 0; k < 16; k++) begin
      bit lp = 1'($urandom);
      foreach (rom[i]) rom[i] = ($urandom % 6 == 0) ? 4'hF : 4'($urandom_range(0, 14));
      txn(lp, lp ? $urandom_range(1, 120) : (($urandom % 3 == 0) ? $urandom_range(1, 60) : 0), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/song_player.md
# song_player

Sequencer that reads the piano's song ROM (5-bit address, 4-bit note code, combinational read) and turns it into a timed stream of notes for the tone generator. It drives the ROM address, samples the returned code once per step, and holds each note for a fixed beat with a short silent gap so repeated notes re-articulate. It sits between the user controls (start/stop/loop) and the note-to-frequency / tone stage.

## Interface
- ADDR_W, 5, ROM address width (32 entries)
- DATA_W, 4, note code width
- BEAT_TICKS, 12_500_000, clock cycles per ROM step excluding the fetch cycle; must be > GAP_TICKS
- GAP_TICKS, 1_250_000, silent cycles at the end of each step; must be ≥ 1

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to play from address 0; ignored while busy
- stop  in  1  single-cycle abort; has priority over start
- loop_en  in  1  1 = restart at address 0 on end of song
- rom_address  out  ADDR_W  address to ROM
- rom_data  in  DATA_W  ROM output, valid in the same cycle as rom_address
- note  out  DATA_W  current note code
- note_valid  out  1  1 = note sounding
- busy  out  1  1 in any state other than IDLE
- done  out  1  one-cycle pulse when song ends without looping

## Operation
- Codes: 4'h0 = rest, 4'hF = end marker, 4'h1–4'hE = notes.
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE: rom_address=0, note=0, note_valid=0, busy=0. start=1 and stop=0 -> FETCH.
- FETCH (1 cycle): sample rom_data.
  - End marker: loop_en=1 -> rom_address<=0, stay in FETCH; else -> DONE.
  - Otherwise: note<=rom_data, note_valid<=(rom_data!=0), load timer -> PLAY.
- PLAY: BEAT_TICKS−GAP_TICKS cycles -> GAP with note_valid<=0; note keeps its value.
- GAP: GAP_TICKS cycles, then:
  - rom_address<ADDR_MAX: rom_address+1 -> FETCH.
  - rom_address=ADDR_MAX (31): loop_en=1 -> address 0, FETCH; loop_en=0 -> DONE.
- DONE (1 cycle): done=1, note<=0, rom_address<=0 -> IDLE.
- stop=1 in any state: next cycle IDLE with all outputs at reset values; done not pulsed.
- loop_en is sampled only at the decision points above.
- An all-end-marker ROM with loop_en=1 spins in FETCH until stop. This is legal.

## Timing
- All outputs are registered. Reset values: rom_address=0, note=0, note_valid=0, busy=0, done=0.
- start sampled at edge n -> FETCH in cycle n+1, note_valid high from n+2.
- note_valid is high for exactly BEAT_TICKS−GAP_TICKS cycles per non-rest entry.
- Step period is BEAT_TICKS+1 cycles (FETCH + PLAY + GAP).
- rom_address changes only on entry to FETCH, and is stable throughout FETCH.
- Asserting rst_n low at any time immediately forces reset values. Playback resumes only on a new start after release.

## Structure
- Shared package piano_pkg:
  - NOTE_REST, NOTE_END
  - ADDR_W, DATA_W
  - state enum
  - used by the ROM, this block and the tone stage.
- Sub-module beat_timer: loadable down-counter with a zero flag, sized to clog2(BEAT_TICKS). It is reused for PLAY and GAP.

## Test plan
Bench uses BEAT_TICKS=4, GAP_TICKS=1 and ROM contents [0]=1, [1]=5, [2]=F unless noted.
- Reset: rst_n low -> all outputs 0; start held during reset -> no activity after release.
- Basic song: start at edge n ->
  - note=1, note_valid=1 in cycles n+2..n+4; gap at n+5.
  - rom_address=1 at n+6; note=5, note_valid=1 in n+7..n+9.
  - FETCH of F at n+11; done=1 at n+12; IDLE with busy=0 at n+13.
- Rest: [1]=0 -> note=0, note_valid stays 0 for that step; step period is still 5 cycles.
- Wrap: all 32 entries =3, no marker.
  - loop_en=1 -> rom_address goes 31->0 and playback continues.
  - loop_en=0 -> done pulse after the address-31 gap.
- Stop and start:
  - stop mid-PLAY -> next cycle note_valid=0, rom_address=0, busy=0, no done.
  - start and stop in the same cycle -> stays IDLE.
  - start while busy -> ignored.
- Reset mid-PLAY: rst_n low -> outputs clear immediately; after release the block remains in IDLE.
